sstv_pixel_sampler: RTL
=======================

// Module: sstv_pixel_sampler
// PURPOSE
//  Parametrised successor to the fixed 2-bit SSTV pixel decoder. Averages 2**AVG_LOG2
//  frequency samples per pixel and quantises the mean to COLOR_W-bit grayscale.
//  Tracks pixel position across a scan line and emits one registered color per pixel.
//  Sits between the tone frequency estimator and the line buffer/framebuffer writer.
// PARAMETERS
//  FREQ_W          12    width of the freq input, unsigned Hz
//  COLOR_W         2     output grayscale depth in bits, 1..8
//  AVG_LOG2        4     log2 of samples averaged per pixel, 0..6
//  FREQ_BLACK      1500  black reference frequency in Hz
//  FREQ_WHITE      2300  white reference frequency in Hz; must be > FREQ_BLACK
//  PIXELS_PER_LINE 320   pixels per scan line, >= 1
// PORTS
//  clk         in   1                  system clock
//  reset       in   1                  asynchronous, active-high reset
//  freq        in   FREQ_W             instantaneous tone frequency in Hz
//  freq_valid  in   1                  freq is a valid sample this cycle
//  line_start  in   1                  one-cycle pulse; starts or restarts a line at pixel 0
//  color       out  COLOR_W            quantised pixel value; held between pulses
//  color_valid out  1                  one-cycle pulse; color and pixel_x are valid
//  pixel_x     out  $clog2(PPL)        index of the pixel presented with color_valid
//  line_done   out  1                  one-cycle pulse, coincident with the last pixel's color_valid
//  busy        out  1                  high while a line is in progress
// BEHAVIOUR
//  Reset (async): all outputs go to 0. FSM enters IDLE. Accumulator, sample counter and pixel counter clear.
//  FSM states:
//   - IDLE: freq_valid is ignored. On line_start, go to ACCUM with pixel 0.
//   - ACCUM: sum += freq on each freq_valid.
//     On the 2**AVG_LOG2-th sample, latch avg = sum >> AVG_LOG2, clear sum, advance the pixel counter.
//     After the last pixel, go to IDLE.
//  Accumulator width is FREQ_W+AVG_LOG2; it never overflows. avg truncates toward zero.
//  Quantiser:
//   - STEP = (FREQ_WHITE-FREQ_BLACK) >> COLOR_W, integer.
//   - Thresholds T_k = FREQ_BLACK + k*STEP, for k = 1..2**COLOR_W-1.
//   - color = number of thresholds with T_k < avg.
//   - Defaults give: <=1700 -> 0, (1700,1900] -> 1, (1900,2100] -> 2, >2100 -> 3.
//  Out-of-range handling:
//   - avg < FREQ_BLACK -> 0.
//   - avg > FREQ_WHITE saturates to all-ones. This is a deliberate change: the legacy block returned black.
//  Latency: the sample that completes a pixel arrives in cycle N -> avg registered in N+1 -> color_valid in N+2.
//  pixel_x and line_done are aligned with color_valid. busy falls in the same cycle as line_done.
//  line_start with freq_valid in the same cycle: that sample counts as sample 0 of pixel 0.
//  line_start in ACCUM: abort the line and restart at pixel 0.
//   - The partial pixel is discarded.
//   - An in-flight avg (cycle N+1) is still emitted with its original pixel_x.
//  line_start on the cycle the last pixel completes: the restart wins; the completed pixel is still emitted.
//  Back-to-back pixels with freq_valid held high: color_valid every 2**AVG_LOG2 cycles, no gaps.
//  Mid-line reset: outputs clear immediately; no pending pulse survives.
// STRUCTURE
//  sstv_pkg holds:
//   - FSM state enum (IDLE, ACCUM).
//   - Default constants FREQ_BLACK=1500, FREQ_WHITE=2300.
//   - Legacy color codes BLACK=0, DARKGRAY=1, LIGHTGRAY=2, WHITE=3.
//  Sub-module sstv_pixel_quant:
//   - Registered comparator ladder, avg -> color.
//   - Constant thresholds generated from parameters; no divider.
//   - Reusable by the colour-mode decoders.
// TESTING
//  1. Reset asserted mid-line -> color=0, color_valid=0, pixel_x=0, line_done=0, busy=0; no stale pulse after release.
//  2. Default params, 16 constant samples per pixel:
//     1700->0, 1701->1, 1900->1, 1901->2, 2100->2, 2101->3, 2300->3, 2500->3, 1200->0.
//  3. Alternating 1600/2000 samples for one pixel -> avg 1800 -> color=1; color_valid exactly 2 cycles after the 16th freq_valid.
//  4. PIXELS_PER_LINE=4, 64 continuous samples -> 4 pulses with pixel_x 0..3.
//     line_done with pixel 3; busy drops; later freq_valid produces no pulse.
//  5. line_start after 10 samples of pixel 2 -> no pulse for the partial pixel; next pulse has pixel_x=0 after 16 more samples.
//  6. COLOR_W=4 (STEP=50) -> 1550->0, 1551->1, 2250->14, 2299->15. AVG_LOG2=0 -> one pulse per sample.

Source files
------------

// File: rtl/sstv_pkg.sv
// rtl/sstv_pkg.sv - shared SSTV decoder types and reference constants
package sstv_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } sstv_state_e;

  localparam int FREQ_BLACK_DEF = 1500;
  localparam int FREQ_WHITE_DEF = 2300;

  // Codes produced by the original fixed 2-bit decoder
  localparam logic [1:0] BLACK     = 2'd0;
  localparam logic [1:0] DARKGRAY  = 2'd1;
  localparam logic [1:0] LIGHTGRAY = 2'd2;
  localparam logic [1:0] WHITE     = 2'd3;

endpackage

// File: rtl/sstv_pixel_quant.sv
// rtl/sstv_pixel_quant.sv - registered threshold ladder mapping a mean frequency to a gray level
module sstv_pixel_quant
  import sstv_pkg::*;
#(
  parameter int FREQ_W     = 12,
  parameter int COLOR_W    = 2,
  parameter int FREQ_BLACK = FREQ_BLACK_DEF,
  parameter int FREQ_WHITE = FREQ_WHITE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [FREQ_W-1:0]  avg_i,
  output logic [COLOR_W-1:0] color_o
);

  localparam int STEP   = (FREQ_WHITE - FREQ_BLACK) >> COLOR_W;
  localparam int LEVELS = 1 << COLOR_W;

  logic [COLOR_W-1:0] color_q, color_d;

  // Highest threshold never exceeds white, so anything above white lands on all-ones
  always_comb begin
    color_d = '0;
    for (int k = 1; k < LEVELS; k++) begin
      if (32'(avg_i) > FREQ_BLACK + k * STEP) begin
        color_d = color_d + COLOR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= '0;
    end else if (en_i) begin
      color_q <= color_d;
    end
  end

  assign color_o = color_q;

endmodule

// File: rtl/sstv_pixel_sampler.sv
// rtl/sstv_pixel_sampler.sv - per-pixel frequency averaging, line tracking and color output
module sstv_pixel_sampler
  import sstv_pkg::*;
#(
  parameter int FREQ_W          = 12,
  parameter int COLOR_W         = 2,
  parameter int AVG_LOG2        = 4,
  parameter int FREQ_BLACK      = FREQ_BLACK_DEF,
  parameter int FREQ_WHITE      = FREQ_WHITE_DEF,
  parameter int PIXELS_PER_LINE = 320,
  localparam int PX_W = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FREQ_W-1:0]  freq,
  input  logic               freq_valid,
  input  logic               line_start,
  output logic [COLOR_W-1:0] color,
  output logic               color_valid,
  output logic [PX_W-1:0]    pixel_x,
  output logic               line_done,
  output logic               busy
);

  localparam int SUM_W = FREQ_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PX_W-1:0]  LAST_PIXEL  = PX_W'(PIXELS_PER_LINE - 1);
  localparam logic [0:0] IDLE  = 1'(ST_IDLE);
  localparam logic [0:0] ACCUM = 1'(ST_ACCUM);

  logic [0:0]        state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_b, acc;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_b;
  logic [PX_W-1:0]   pix_q, pix_d, pix_b;
  logic              avg_vld_q, avg_vld_d, avg_last_q, avg_last_d;
  logic [FREQ_W-1:0] avg_q, avg_d;
  logic [PX_W-1:0]   avg_px_q, avg_px_d;
  logic              out_vld_q, out_done_q;
  logic [PX_W-1:0]   out_px_q;
  logic              old_done, fresh, take;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    avg_vld_d  = 1'b0;
    avg_d      = avg_q;
    avg_px_d   = avg_px_q;
    avg_last_d = avg_last_q;
    // A sample that completes the running pixel belongs to it even if a restart arrives alongside
    old_done = freq_valid && (state_q == ACCUM) && (cnt_q == LAST_SAMPLE);
    fresh    = line_start && !old_done;
    sum_b    = fresh ? '0 : sum_q;
    cnt_b    = fresh ? '0 : cnt_q;
    pix_b    = fresh ? '0 : pix_q;
    take     = freq_valid && ((state_q == ACCUM) || line_start);
    acc      = sum_b + SUM_W'(freq);

    if (line_start) begin
      state_d = ACCUM;
    end
    if (take) begin
      if (cnt_b == LAST_SAMPLE) begin
        avg_vld_d  = 1'b1;
        avg_d      = FREQ_W'(acc >> AVG_LOG2);
        avg_px_d   = pix_b;
        avg_last_d = (pix_b == LAST_PIXEL);
        sum_d      = '0;
        cnt_d      = '0;
        if (pix_b == LAST_PIXEL) begin
          pix_d   = '0;
          state_d = (old_done && line_start) ? ACCUM : IDLE;
        end else begin
          pix_d = pix_b + PX_W'(1);
        end
      end else begin
        sum_d = acc;
        cnt_d = cnt_b + CNT_W'(1);
        pix_d = pix_b;
      end
    end else if (line_start) begin
      sum_d = '0;
      cnt_d = '0;
      pix_d = '0;
    end
    if (old_done && line_start) begin
      sum_d = '0;
      cnt_d = '0;
      pix_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      avg_vld_q  <= 1'b0;
      avg_q      <= '0;
      avg_px_q   <= '0;
      avg_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_px_q   <= '0;
      out_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      avg_vld_q  <= avg_vld_d;
      avg_q      <= avg_d;
      avg_px_q   <= avg_px_d;
      avg_last_q <= avg_last_d;
      out_vld_q  <= avg_vld_q;
      out_done_q <= avg_vld_q && avg_last_q;
      if (avg_vld_q) begin
        out_px_q <= avg_px_q;
      end
    end
  end

  sstv_pixel_quant #(
    .FREQ_W     (FREQ_W),
    .COLOR_W    (COLOR_W),
    .FREQ_BLACK (FREQ_BLACK),
    .FREQ_WHITE (FREQ_WHITE)
  ) u_quant (
    .clk     (clk),
    .reset   (reset),
    .en_i    (avg_vld_q),
    .avg_i   (avg_q),
    .color_o (color)
  );

  assign color_valid = out_vld_q;
  assign pixel_x     = out_px_q;
  assign line_done   = out_done_q;
  // Held through the last pixel's trip down the pipe so it drops together with line_done
  assign busy        = (state_q == ACCUM) || (avg_vld_q && avg_last_q);

endmodule
